// File: rtl/gift_iter_ctrl.sv
// Iterative GIFT-128 encryption controller: one round datapath reused for ROUNDS
// clock cycles, with valid/ready handshakes on both the block input and the ciphertext output.
module gift_iter_ctrl #(
  parameter int unsigned ROUNDS     = 40,
  parameter logic [5:0]  INIT_CONST = 6'h00
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inValid,
  output logic         outReady,
  input  logic [127:0] inData,
  input  logic [127:0] inKey,
  output logic         outValid,
  input  logic         inReady,
  output logic [127:0] outData,
  output logic         outBusy,
  output logic [5:0]   outRound
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] gift_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h1;
      4'h1: y = 4'ha;
      4'h2: y = 4'h4;
      4'h3: y = 4'hc;
      4'h4: y = 4'h6;
      4'h5: y = 4'hf;
      4'h6: y = 4'h3;
      4'h7: y = 4'h9;
      4'h8: y = 4'h2;
      4'h9: y = 4'hd;
      4'ha: y = 4'hb;
      4'hb: y = 4'h7;
      4'hc: y = 4'h5;
      4'hd: y = 4'h0;
      4'he: y = 4'h8;
      4'hf: y = 4'he;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // SubCells, PermBits, AddRoundKey (U = k5||k4, V = k1||k0), AddConstant.
  function automatic logic [127:0] gift_round_fun(input logic [127:0] s,
                                                   input logic [127:0] k,
                                                   input logic [5:0]   c);
    logic [127:0] sub_v;
    logic [127:0] perm_v;
    logic [31:0]  u_v;
    logic [31:0]  v_v;
    for (int i = 0; i < 32; i++) begin
      sub_v[4*i +: 4] = gift_sbox(s[4*i +: 4]);
    end
    perm_v = 128'd0;
    for (int i = 0; i < 128; i++) begin
      perm_v[7'(4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4))] = sub_v[i];
    end
    u_v = k[95:64];
    v_v = k[31:0];
    for (int i = 0; i < 32; i++) begin
      perm_v[4*i+2] = perm_v[4*i+2] ^ u_v[i];
      perm_v[4*i+1] = perm_v[4*i+1] ^ v_v[i];
    end
    perm_v[127] = perm_v[127] ^ 1'b1;
    perm_v[23]  = perm_v[23]  ^ c[5];
    perm_v[19]  = perm_v[19]  ^ c[4];
    perm_v[15]  = perm_v[15]  ^ c[3];
    perm_v[11]  = perm_v[11]  ^ c[2];
    perm_v[7]   = perm_v[7]   ^ c[1];
    perm_v[3]   = perm_v[3]   ^ c[0];
    return perm_v;
  endfunction

  // k7..k0 <- (k1 >>> 2) || (k0 >>> 12) || k7..k2, rotations within 16-bit words.
  function automatic logic [127:0] gift_keysch_fun(input logic [127:0] k);
    return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
  endfunction

  function automatic logic [5:0] gift_const_fun(input logic [5:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

  state_t       state_q,     state_d;
  logic [127:0] data_q,      data_d;
  logic [127:0] key_q,       key_d;
  logic [5:0]   const_q,     const_d;
  logic [5:0]   round_q,     round_d;
  logic         out_ready_q, out_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         out_busy_q,  out_busy_d;

  // Next-state logic for the round sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    const_d = const_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          data_d  = inData;
          key_d   = inKey;
          const_d = INIT_CONST;
          round_d = 6'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        data_d  = gift_round_fun(data_q, key_q, const_q);
        key_d   = gift_keysch_fun(key_q);
        const_d = gift_const_fun(const_q);
        if (round_q == LAST_ROUND) begin
          round_d = 6'd0;
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 6'd1;
        end
      end
      ST_DONE: begin
        if (inReady) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 6'd0;
      end
    endcase
    out_ready_d = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    out_busy_d  = (state_d == ST_RUN);
  end

  // State and output registers; reset discards any block in flight.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q     <= ST_IDLE;
      data_q      <= 128'd0;
      key_q       <= 128'd0;
      const_q     <= INIT_CONST;
      round_q     <= 6'd0;
      out_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      key_q       <= key_d;
      const_q     <= const_d;
      round_q     <= round_d;
      out_ready_q <= out_ready_d;
      out_valid_q <= out_valid_d;
      out_busy_q  <= out_busy_d;
    end
  end

  assign outReady = out_ready_q;
  assign outValid = out_valid_q;
  assign outBusy  = out_busy_q;
  assign outData  = data_q;
  assign outRound = round_q;

endmodule

// File: tb/tb_gift_iter_ctrl.sv
// Randomized scoreboard bench for gift_iter_ctrl (ROUNDS=40 main instance, ROUNDS=1 side instance)
// against a word/array-level GIFT-128 reference model.
module tb_gift_iter_ctrl;

  localparam logic [5:0] INIT_C = 6'h00;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready = 1'b1;
  logic [127:0] in_data = 128'd0, in_key = 128'd0;
  logic         out_ready, out_valid, out_busy;
  logic [127:0] out_data;
  logic [5:0]   out_round;

  logic         r1_in_valid = 1'b0, r1_in_ready = 1'b1;
  logic [127:0] r1_in_data = 128'd0, r1_in_key = 128'd0;
  logic         r1_out_ready, r1_out_valid, r1_out_busy;
  logic [127:0] r1_out_data;
  logic [5:0]   r1_out_round;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gift_iter_ctrl #(.ROUNDS(40), .INIT_CONST(INIT_C)) dut (
    .inClk(clk), .inRst(rst), .inValid(in_valid), .outReady(out_ready),
    .inData(in_data), .inKey(in_key), .outValid(out_valid), .inReady(in_ready),
    .outData(out_data), .outBusy(out_busy), .outRound(out_round)
  );

  gift_iter_ctrl #(.ROUNDS(1), .INIT_CONST(INIT_C)) dut1 (
    .inClk(clk), .inRst(rst), .inValid(r1_in_valid), .outReady(r1_out_ready),
    .inData(r1_in_data), .inKey(r1_in_key), .outValid(r1_out_valid), .inReady(r1_in_ready),
    .outData(r1_out_data), .outBusy(r1_out_busy), .outRound(r1_out_round)
  );

  // Reference model: nibble/word arithmetic on integer arrays.
  function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k, input int c);
    int sb[16] = '{1, 10, 4, 12, 6, 15, 3, 9, 2, 13, 11, 7, 5, 0, 8, 14};
    bit t[128];
    bit p[128];
    logic [127:0] r;
    int nib;
    int kw[8];
    int u, v;
    for (int n = 0; n < 32; n++) begin
      nib = int'((s >> (4*n)) & 128'hf);
      nib = sb[nib];
      for (int b = 0; b < 4; b++) t[4*n+b] = bit'((nib >> b) & 1);
    end
    for (int i = 0; i < 128; i++)
      p[4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4)] = t[i];
    for (int w = 0; w < 8; w++) kw[w] = int'((k >> (16*w)) & 128'hffff);
    u = kw[5] * 65536 + kw[4];
    v = kw[1] * 65536 + kw[0];
    for (int i = 0; i < 32; i++) begin
      p[4*i+2] ^= bit'((u >> i) & 1);
      p[4*i+1] ^= bit'((v >> i) & 1);
    end
    p[127] ^= 1'b1;
    for (int j = 0; j < 6; j++) p[3 + 4*j] ^= bit'((c >> j) & 1);
    for (int i = 0; i < 128; i++) r[i] = p[i];
    return r;
  endfunction

  function automatic int rotr16(input int w, input int n);
    return ((w >> n) | (w << (16 - n))) & 16'hffff;
  endfunction

  function automatic logic [127:0] m_keysch(input logic [127:0] k);
    int w[8];
    int nw[8];
    logic [127:0] r;
    for (int i = 0; i < 8; i++) w[i] = int'((k >> (16*i)) & 128'hffff);
    for (int i = 0; i < 6; i++) nw[i] = w[i+2];
    nw[6] = rotr16(w[0], 12);
    nw[7] = rotr16(w[1], 2);
    r = 128'd0;
    for (int i = 7; i >= 0; i--) r = (r << 16) | 128'(nw[i]);
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input int n);
    int c = int'(INIT_C);
    for (int r = 0; r < n; r++) begin
      d = m_round(d, k, c);
      k = m_keysch(k);
      c = ((c << 1) & 62) | (((c >> 5) ^ (c >> 4) ^ 1) & 1);
    end
    return d;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] d, input logic [127:0] k);
    for (int t = 0; t < 200 && !out_ready; t++) tick();
    check("accept_ready", 128'(out_ready), 128'd1);
    in_data = d;
    in_key = k;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(d, k, 40));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    for (t = 0; t < 200 && !out_valid; t++) tick();
    if (!out_valid) check("wait_valid_timeout", 128'(out_valid), 128'd1);
  endtask

  // Scoreboard monitor: every output handshake pops one expected block.
  always @(negedge clk) begin
    if (!rst && out_valid && in_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 128'(out_valid), 128'd0);
      else check("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d, k, e;
    int acc, last_acc;

    // Reset and idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", 128'(out_ready), 128'd1);
      check("idle_valid", 128'(out_valid), 128'd0);
      check("idle_busy", 128'(out_busy), 128'd0);
      check("idle_data", out_data, 128'd0);
      check("idle_round", 128'(out_round), 128'd0);
    end
    check("r1_idle_ready", 128'(r1_out_ready), 128'd1);

    // All-zero block: busy for 40 cycles, round index 0..39, valid after 40 edges
    in_ready = 1'b1;
    accept(128'd0, 128'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("run_busy", 128'(out_busy), 128'd1);
      check("run_round", 128'(out_round), 128'(i));
      check("run_no_valid", 128'(out_valid), 128'd0);
    end
    @(negedge clk);
    check("valid_at_40", 128'(out_valid), 128'd1);
    check("busy_end", 128'(out_busy), 128'd0);
    tick(); tick();

    // Backpressure: output held stable for 17 cycles
    d = rand128();
    k = rand128();
    e = model(d, k, 40);
    in_ready = 1'b0;
    accept(d, k);
    wait_valid();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("hold_valid", 128'(out_valid), 128'd1);
      check("hold_data", out_data, e);
      check("hold_ready", 128'(out_ready), 128'd0);
    end
    in_ready = 1'b1;
    @(negedge clk);
    tick();
    check("release_valid", 128'(out_valid), 128'd0);
    check("release_ready", 128'(out_ready), 128'd1);

    // Back-to-back blocks with inputs scrambled during RUN
    acc = 0;
    last_acc = 0;
    in_data = rand128();
    in_key = rand128();
    in_valid = 1'b1;
    for (int t = 0; t < 300 && acc < 3; t++) begin
      @(negedge clk);
      if (out_ready) begin
        @(posedge clk);
        exp_q.push_back(model(in_data, in_key, 40));
        #1;
        if (acc > 0) check("accept_period", 128'(cyc - last_acc), 128'd42);
        last_acc = cyc;
        acc++;
        if (acc == 3) in_valid = 1'b0;
      end else begin
        tick();
      end
      in_data = rand128();
      in_key = rand128();
    end
    check("b2b_accepts", 128'(acc), 128'd3);
    wait_valid();
    tick(); tick();
    check("b2b_drain", 128'(exp_q.size()), 128'd0);

    // Reset mid-run discards the block; next block must start from fresh state
    accept(rand128(), rand128());
    for (int i = 0; i < 20; i++) tick();
    check("pre_rst_round", 128'(out_round), 128'd20);
    rst = 1'b1;
    tick();
    void'(exp_q.pop_back());
    check("rst_ready", 128'(out_ready), 128'd1);
    check("rst_busy", 128'(out_busy), 128'd0);
    check("rst_data", out_data, 128'd0);
    check("rst_round", 128'(out_round), 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      check("rst_no_valid", 128'(out_valid), 128'd0);
    end
    tick();
    accept(rand128(), rand128());
    wait_valid();
    tick(); tick();
    check("rst_drain", 128'(exp_q.size()), 128'd0);

    // ROUNDS=1 instance: single round, valid one cycle after accept
    for (int v = 0; v < 4; v++) begin
      d = rand128();
      k = rand128();
      r1_in_data = d;
      r1_in_key = k;
      r1_in_valid = 1'b1;
      @(posedge clk);
      #1;
      r1_in_valid = 1'b0;
      @(negedge clk);
      check("r1_busy", 128'(r1_out_busy), 128'd1);
      check("r1_early_valid", 128'(r1_out_valid), 128'd0);
      @(negedge clk);
      check("r1_valid", 128'(r1_out_valid), 128'd1);
      check("r1_data", r1_out_data, model(d, k, 1));
      @(negedge clk);
      check("r1_back_idle", 128'(r1_out_ready), 128'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
